// File: rtl/zeroriscy_multdiv_slow.sv
`default_nettype none
// ============================================================================
// Module      : zeroriscy_multdiv_slow
// Description : Iterative RV32M multiply/divide unit. One add per cycle via
//               the shared ALU adder (operands {x,1}/{y,0} or {~y,1}; the
//               33-bit sum is taken from adder bits [33:1]).
// Revision    : 1.0 - initial release
// ============================================================================
module zeroriscy_multdiv_slow (
  input  logic        clk,
  input  logic        rst,
  input  logic        mult_en_i,
  input  logic        div_en_i,
  input  logic [1:0]  operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [33:0] alu_adder_ext_i,
  output logic [32:0] alu_operand_a_o,
  output logic [32:0] alu_operand_b_o,
  output logic        multdiv_en_o,
  output logic [31:0] multdiv_result_o,
  output logic        ready_o
);

  localparam logic [1:0] c_OP_MUL  = 2'b00;
  localparam logic [1:0] c_OP_MULH = 2'b01;
  localparam logic [1:0] c_OP_REM  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    A_ABS  = 3'd1,
    B_ABS  = 3'd2,
    COMP   = 3'd3,
    LAST   = 3'd4,
    FINISH = 3'd5
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_acc;       // mult: high product window / div: partial remainder
  logic [31:0] r_shift;     // mult: multiplier -> low product / div: dividend -> quotient
  logic [31:0] r_opnd;      // mult: multiplicand / div: divisor magnitude
  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic [1:0]  r_op;
  logic        r_a_sgn;     // multiplicand treated as signed
  logic        r_a_neg;     // op_a signed and negative
  logic        r_b_neg;     // op_b signed and negative
  logic        r_div_zero;
  logic [31:0] r_result;

  logic [32:0] w_sum;
  logic        w_unused_ext_lsb;
  logic        w_start;
  logic        w_active_en;
  logic        w_a_sgn, w_b_sgn;
  logic [31:0] w_mul_addend;
  logic        w_mul_top;
  logic [31:0] w_div_x;
  logic        w_qbit;
  logic [31:0] w_div_val;
  logic        w_div_neg;

  assign w_sum            = alu_adder_ext_i[33:1];
  assign w_unused_ext_lsb = alu_adder_ext_i[0];
  assign w_start          = mult_en_i | div_en_i;
  assign w_active_en      = r_is_div ? div_en_i : mult_en_i;

  // Signedness only matters for divides and the MULH family; MUL low word is sign-independent.
  assign w_a_sgn = signed_mode_i[0] & (div_en_i | (operator_i == c_OP_MULH));
  assign w_b_sgn = signed_mode_i[1] & (div_en_i | (operator_i == c_OP_MULH));

  // Shift-add: when the multiplicand is signed the window is signed, so the
  // true sign of the 33-bit sum is rebuilt from operand signs (no overflow
  // possible when signs differ, sign of either operand when they agree).
  assign w_mul_addend = r_shift[0] ? r_opnd : 32'd0;
  assign w_mul_top    = r_a_sgn ? ((r_acc[31] == w_mul_addend[31]) ? r_acc[31] : w_sum[31])
                                : w_sum[32];

  // Restoring division: a set remainder MSB means the shifted value already exceeds any divisor.
  assign w_div_x   = {r_acc[30:0], r_shift[31]};
  assign w_qbit    = r_acc[31] | w_sum[32];
  assign w_div_val = (r_op == c_OP_REM) ? r_acc : r_shift;
  assign w_div_neg = (r_op == c_OP_REM) ? r_a_neg : ((r_a_neg ^ r_b_neg) & ~r_div_zero);

  assign ready_o          = (r_state == FINISH);
  assign multdiv_result_o = r_result;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and ALU adder operand steering.
  always_comb begin
    w_state_nxt     = r_state;
    alu_operand_a_o = 33'd0;
    alu_operand_b_o = 33'd0;
    multdiv_en_o    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) w_state_nxt = div_en_i ? A_ABS : COMP;
      end
      A_ABS: begin
        multdiv_en_o    = 1'b1;
        alu_operand_a_o = {32'd0, 1'b1};
        alu_operand_b_o = r_a_neg ? {~r_shift, 1'b1} : {r_shift, 1'b0};
        w_state_nxt     = B_ABS;
      end
      B_ABS: begin
        multdiv_en_o    = 1'b1;
        alu_operand_a_o = {32'd0, 1'b1};
        alu_operand_b_o = r_b_neg ? {~r_opnd, 1'b1} : {r_opnd, 1'b0};
        w_state_nxt     = COMP;
      end
      COMP: begin
        multdiv_en_o = 1'b1;
        if (r_is_div) begin
          alu_operand_a_o = {w_div_x, 1'b1};
          alu_operand_b_o = {~r_opnd, 1'b1};
        end else begin
          alu_operand_a_o = {r_acc, 1'b1};
          alu_operand_b_o = {w_mul_addend, 1'b0};
        end
        if (r_cnt == 5'd0) w_state_nxt = LAST;
      end
      LAST: begin
        multdiv_en_o = 1'b1;
        if (r_is_div) begin
          alu_operand_a_o = {32'd0, 1'b1};
          alu_operand_b_o = w_div_neg ? {~w_div_val, 1'b1} : {w_div_val, 1'b0};
        end else begin
          alu_operand_a_o = {r_acc, 1'b1};
          alu_operand_b_o = r_b_neg ? {~r_opnd, 1'b1} : {32'd0, 1'b0};
        end
        w_state_nxt = FINISH;
      end
      FINISH: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if ((r_state != IDLE) && (r_state != FINISH) && !w_active_en) w_state_nxt = IDLE;
  end

  // Datapath: operand capture, abs conversion, iteration and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= 32'd0;
      r_shift    <= 32'd0;
      r_opnd     <= 32'd0;
      r_cnt      <= 5'd0;
      r_is_div   <= 1'b0;
      r_op       <= 2'b00;
      r_a_sgn    <= 1'b0;
      r_a_neg    <= 1'b0;
      r_b_neg    <= 1'b0;
      r_div_zero <= 1'b0;
      r_result   <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_is_div   <= div_en_i;
            r_op       <= operator_i;
            r_cnt      <= 5'd31;
            r_acc      <= 32'd0;
            r_div_zero <= 1'b0;
            r_a_sgn    <= w_a_sgn;
            r_a_neg    <= w_a_sgn & op_a_i[31];
            r_b_neg    <= w_b_sgn & op_b_i[31];
            if (div_en_i) begin
              r_shift <= op_a_i;
              r_opnd  <= op_b_i;
            end else begin
              r_shift <= op_b_i;
              r_opnd  <= op_a_i;
            end
          end
        end
        A_ABS: r_shift <= w_sum[31:0];
        B_ABS: begin
          r_opnd     <= w_sum[31:0];
          r_div_zero <= (r_opnd == 32'd0);
        end
        COMP: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_is_div) begin
            r_acc   <= w_qbit ? w_sum[31:0] : w_div_x;
            r_shift <= {r_shift[30:0], w_qbit};
          end else begin
            r_acc   <= {w_mul_top, w_sum[31:1]};
            r_shift <= {w_sum[0], r_shift[31:1]};
          end
        end
        LAST: begin
          if (w_state_nxt == FINISH)
            r_result <= (!r_is_div && (r_op == c_OP_MUL)) ? r_shift : w_sum[31:0];
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zeroriscy_multdiv_slow.sv
`default_nettype none
// ============================================================================
// Module      : tb_zeroriscy_multdiv_slow
// Description : Self-checking bench for zeroriscy_multdiv_slow with an ALU
//               adder model, an arithmetic reference model and directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zeroriscy_multdiv_slow;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mult_en = 1'b0;
  logic        div_en = 1'b0;
  logic [1:0]  operator = 2'b00;
  logic [1:0]  signed_mode = 2'b00;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [33:0] alu_ext;
  logic [32:0] alu_a, alu_b;
  logic        multdiv_en;
  logic [31:0] result;
  logic        ready;

  int          checks = 0;
  int          errors = 0;
  logic        pending = 1'b0;
  logic [31:0] model_res = 32'd0;

  zeroriscy_multdiv_slow dut (
    .clk              (clk),
    .rst              (rst),
    .mult_en_i        (mult_en),
    .div_en_i         (div_en),
    .operator_i       (operator),
    .signed_mode_i    (signed_mode),
    .op_a_i           (op_a),
    .op_b_i           (op_b),
    .alu_adder_ext_i  (alu_ext),
    .alu_operand_a_o  (alu_a),
    .alu_operand_b_o  (alu_b),
    .multdiv_en_o     (multdiv_en),
    .multdiv_result_o (result),
    .ready_o          (ready)
  );

  // Shared ALU adder: plain 34-bit sum of the two 33-bit operands.
  assign alu_ext = {1'b0, alu_a} + {1'b0, alu_b};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: RV32M semantics from wide arithmetic on extended operands.
  function automatic logic [31:0] model(input logic is_div, input logic [1:0] op,
                                        input logic [1:0] sm, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0]        ax, bx, p;
    logic signed [63:0] sa, sb, q, r;
    ax = {{32{sm[0] & a[31]}}, a};
    bx = {{32{sm[1] & b[31]}}, b};
    if (!is_div) begin
      p = ax * bx;
      return (op == 2'b00) ? p[31:0] : p[63:32];
    end
    if (b == 32'd0) return (op == 2'b10) ? 32'hFFFF_FFFF : a;
    sa = ax;
    sb = bx;
    q  = sa / sb;
    r  = sa % sb;
    return (op == 2'b10) ? q[31:0] : r[31:0];
  endfunction

  // Every completion strobe is checked against the reference model.
  always @(negedge clk) begin
    if (!rst && ready) begin
      chk("ready_expected", {63'd0, pending}, 64'd1);
      if (pending) chk("model_result", result, model_res);
    end
  end

  // Caller is in IDLE at posedge+1 (b2b=0) or in FINISH at negedge+1 with enables held (b2b=1).
  task automatic run_op(input string name, input logic me, input logic de, input logic [1:0] op,
                        input logic [1:0] sm, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input bit b2b, input bit keep);
    int n, en_cnt;
    bit seen;
    mult_en = me; div_en = de; operator = op; signed_mode = sm; op_a = a; op_b = b;
    model_res = model(de, op, sm, a, b);
    pending = 1'b1;
    n = 0; en_cnt = 0; seen = 0;
    while (!seen && n < 80) begin
      @(posedge clk); #1;
      n++;
      if (multdiv_en) en_cnt++;
      if (ready) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_ready required=ready", name);
      pending = 1'b0; mult_en = 1'b0; div_en = 1'b0;
      @(posedge clk); #1;
      return;
    end
    chk({name, "_latency"}, n, (de ? 36 : 34) + (b2b ? 1 : 0));
    chk({name, "_en_cycles"}, en_cnt, de ? 35 : 33);
    chk({name, "_result"}, result, lit);
    @(negedge clk); #1;
    pending = 1'b0;
    if (!keep) begin
      mult_en = 1'b0; div_en = 1'b0;
      @(posedge clk); #1;
      chk({name, "_ready_drop"}, ready, 0);
      chk({name, "_en_idle"}, multdiv_en, 0);
    end
  endtask

  initial begin
    int rc;
    #2;
    chk("rst_ready", ready, 0);
    chk("rst_en", multdiv_en, 0);
    chk("rst_result", result, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    run_op("mul",      1, 0, 2'b00, 2'b00, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0);
    run_op("mulh_ss",  1, 0, 2'b01, 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0);
    run_op("mulhu_a",  1, 0, 2'b01, 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0);
    run_op("mulhu_b",  1, 0, 2'b01, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
    run_op("mulhsu",   1, 0, 2'b01, 2'b01, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0, 0);
    run_op("mulh_neg", 1, 0, 2'b01, 2'b11, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 0, 0);
    run_op("div_s",    0, 1, 2'b10, 2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 0);
    run_op("rem_s",    0, 1, 2'b11, 2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, 0);
    run_op("divu",     0, 1, 2'b10, 2'b00, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC, 0, 0);
    run_op("divu_z",   0, 1, 2'b10, 2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, 0, 0);
    run_op("remu_z",   0, 1, 2'b11, 2'b00, 32'd5,         32'd0,         32'd5,         0, 0);
    run_op("div_z",    0, 1, 2'b10, 2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 0, 0);
    run_op("rem_z",    0, 1, 2'b11, 2'b11, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 0, 0);
    run_op("div_ovf",  0, 1, 2'b10, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    run_op("rem_ovf",  0, 1, 2'b11, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, 0);
    run_op("remu",     0, 1, 2'b11, 2'b00, 32'd100,       32'd7,         32'd2,         0, 0);
    run_op("div_big",  0, 1, 2'b10, 2'b11, 32'h1234_5678, 32'hFFFF_FF00, 32'hFFED_CBAA, 0, 0);
    run_op("rem_big",  0, 1, 2'b11, 2'b11, 32'h1234_5678, 32'hFFFF_FF00, 32'h0000_0078, 0, 0);

    // Multiply aborted in the tenth COMP cycle.
    mult_en = 1'b1; operator = 2'b00; signed_mode = 2'b00; op_a = 32'd3; op_b = 32'd9;
    repeat (10) @(posedge clk);
    #1;
    mult_en = 1'b0;
    @(posedge clk); #1;
    chk("abort_mul_en", multdiv_en, 0);
    chk("abort_mul_ready", ready, 0);
    rc = 0;
    repeat (40) begin @(posedge clk); #1; if (ready) rc++; end
    chk("abort_mul_no_ready", rc, 0);

    // Divide aborted in B_ABS.
    div_en = 1'b1; operator = 2'b10; signed_mode = 2'b11; op_a = 32'd50; op_b = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    div_en = 1'b0;
    @(posedge clk); #1;
    chk("abort_div_en", multdiv_en, 0);
    rc = 0;
    repeat (40) begin @(posedge clk); #1; if (ready) rc++; end
    chk("abort_div_no_ready", rc, 0);

    // Asynchronous reset in the middle of a divide.
    div_en = 1'b1; operator = 2'b10; signed_mode = 2'b00; op_a = 32'd1000; op_b = 32'd3;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; div_en = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_en", multdiv_en, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_b", alu_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("after_rst", 0, 1, 2'b10, 2'b00, 32'd1000, 32'd3, 32'd333, 0, 0);

    // Back-to-back with both enables high: divide wins each time.
    run_op("b2b_div", 1, 1, 2'b10, 2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 1);
    run_op("b2b_rem", 1, 1, 2'b11, 2'b11, 32'd100,       32'hFFFF_FFF9, 32'd2,         1, 1);
    run_op("b2b_mul", 1, 0, 2'b00, 2'b00, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/zeroriscy_multdiv_slow.md
Name: zeroriscy_multdiv_slow

Overview:
Iterative multiply/divide unit for the zero-riscy EX stage. It implements the RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU instructions and performs one addition per cycle. It has no adder of its own: every add/subtract goes through the shared ALU adder via the multdiv operand/enable path, and the unit consumes the ALU's 34-bit extended adder result.

Parameters:
- None. Datapath is fixed at 32 bits; iteration count is fixed at 32.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
mult_en_i  in  1  request multiply; held high until ready_o
div_en_i  in  1  request divide; held high until ready_o
operator_i  in  2  00 MUL, 01 MULH, 10 DIV, 11 REM
signed_mode_i  in  2  bit0 = op_a signed, bit1 = op_b signed
op_a_i  in  32  rs1 operand; stable while enable is high
op_b_i  in  32  rs2 operand; stable while enable is high
alu_adder_ext_i  in  34  ALU extended adder result; sum = bits [33:1]
alu_operand_a_o  out  33  to ALU adder input a, format {x,1'b1}
alu_operand_b_o  out  33  to ALU adder input b; {y,1'b0} to add, {~y,1'b1} to subtract
multdiv_en_o  out  1  steers the ALU adder to the multdiv operands
multdiv_result_o  out  32  result; valid only while ready_o=1
ready_o  out  1  one-cycle completion strobe

Behaviour:
- Reset values:
  - State IDLE.
  - ready_o=0, multdiv_en_o=0, multdiv_result_o=0, alu_operand_a_o=0, alu_operand_b_o=0.
  - All internal registers (accumulator, operand shadows, counter) cleared.
- Request arbitration:
  - An operation starts in IDLE when mult_en_i|div_en_i=1.
  - If both are high, div_en_i wins and the request is treated as a divide.
  - operator_i is sampled together with the enables; an operator/enable mismatch (e.g. mult_en_i with DIV) is undefined, so the verification bench does not drive it.
- Operand extension: operands are treated as 33-bit, with bit32 = signed_mode bit ? sign bit : 0. MUL ignores signed_mode; its low word is sign-independent.
- FSM states: IDLE, A_ABS, B_ABS, COMP, LAST, FINISH.
- Multiply path: IDLE -> COMP (32 cycles, counter 31..0) -> LAST -> FINISH -> IDLE.
  - COMP: shift-add, one conditional add per cycle.
  - LAST: signed-b correction (subtract) for MULH variants.
- Divide path: IDLE -> A_ABS -> B_ABS -> COMP (32 cycles) -> LAST -> FINISH -> IDLE.
  - A_ABS/B_ABS: 0 - x through the ALU when the operand is signed and negative.
  - COMP: restoring division, one trial subtract per cycle.
  - LAST: applies the sign to the quotient (a_sign ^ b_sign) or to the remainder (a_sign).
- Latency, counted from the cycle in IDLE where the enable is sampled high:
  - ready_o asserts 34 cycles later for multiply, 36 for divide.
  - Latency is fixed and data-independent, including divide-by-zero and overflow.
- Handshake:
  - ready_o is high exactly one cycle, in FINISH.
  - multdiv_result_o is registered and stable during that cycle.
  - The FSM returns to IDLE on the next edge.
  - A new op may be sampled in that IDLE cycle, i.e. the earliest restart is one cycle after ready_o.
- multdiv_en_o = (state != IDLE) && (state != FINISH). The ALU adder is free in IDLE and FINISH.
- Results, RV32M exact:
  - MUL: low 32 bits of a*b.
  - MULH: high 32 bits of the 66-bit product of the extended operands.
  - Divide by zero: quotient 0xFFFFFFFF for both signed and unsigned; remainder = op_a_i. This is detected in B_ABS and must override the sign correction.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0.
- Abort: if the active enable drops before FINISH, the FSM returns to IDLE on the next edge, ready_o stays 0, and no result is produced.
- Asynchronous reset mid-operation forces IDLE and the reset values immediately; the next request restarts cleanly.

Test Plan:
- MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB; ready_o exactly 34 cycles after the enable; multdiv_en_o high for 33 cycles.
- MULH on 0x80000000*0x80000000:
  - signed_mode=11 -> 0x40000000
  - signed_mode=00 (MULHU) -> 0x40000000
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF
- DIV/REM -7 by 2 with signed_mode=11 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU of the same operands -> quotient 0x7FFFFFFC. Latency 36.
- Divide by zero: 5/0 -> DIV 0xFFFFFFFF, REM 5. Signed -5/0 -> DIV 0xFFFFFFFF, REM 0xFFFFFFFB.
- Overflow: 0x80000000 / 0xFFFFFFFF signed -> DIV 0x80000000, REM 0.
- Control:
  - Drop the enable at COMP cycle 10 -> IDLE next cycle, no ready_o.
  - Assert rst mid-divide -> outputs zero immediately.
  - Back-to-back ops with mult_en_i and div_en_i both high -> divide executed, results correct.
